// File: rtl/lia_pkg.sv
// Shared definitions for the dual-phase lock-in demodulator.
//   DW     - signed width of ADC and reference samples
//   OUT_W  - signed width of the I/Q results
//   CNT_W  - width of the internal window-length counter
//   ACC_W  - accumulator width; holds 2*DW + CNT_W bits so a maximum-length
//            window of full-scale products cannot overflow
//   mode_t - window termination source (external dump or internal counter)
package lia_pkg;

   localparam int DW    = 14;
   localparam int OUT_W = 14;
   localparam int CNT_W = 24;
   localparam int ACC_W = 52;

   typedef enum logic {
      MODE_EXT = 1'b0,
      MODE_INT = 1'b1
   } mode_t;

endpackage

// File: rtl/lock_in_iq_demod_if.sv
// Sample/result bus of the lock-in demodulator.
//   master : drives the ADC sample, I/Q references and window controls,
//            receives the I/Q results, valid pulse, clip flag and window count
//   slave  : the demodulator side
// Signals:
//   adc_i, ref_i_i, ref_q_i  signed samples, one per clock
//   mode_i                   0 = window ends on dump_i, 1 = internal counter
//   dump_i                   current sample is the last of its window
//   win_len_i                internal window = win_len_i + 1 samples
//   shift_i                  arithmetic right shift before saturation
//   i_o, q_o                 saturated results, held between valid pulses
//   valid_o                  one-cycle pulse when i_o/q_o update
//   ovf_o                    either result clipped (only with valid_o)
//   win_cnt_o                completed windows, wraps at 2^16
interface lock_in_iq_demod_if #(
   parameter int DW    = lia_pkg::DW,
   parameter int OUT_W = lia_pkg::OUT_W,
   parameter int CNT_W = lia_pkg::CNT_W
);

   logic signed [DW-1:0]    adc_i;
   logic signed [DW-1:0]    ref_i_i;
   logic signed [DW-1:0]    ref_q_i;
   logic                    mode_i;
   logic                    dump_i;
   logic [CNT_W-1:0]        win_len_i;
   logic [5:0]              shift_i;
   logic signed [OUT_W-1:0] i_o;
   logic signed [OUT_W-1:0] q_o;
   logic                    valid_o;
   logic                    ovf_o;
   logic [15:0]             win_cnt_o;

   modport master (
      output adc_i, ref_i_i, ref_q_i, mode_i, dump_i, win_len_i, shift_i,
      input  i_o, q_o, valid_o, ovf_o, win_cnt_o
   );

   modport slave (
      input  adc_i, ref_i_i, ref_q_i, mode_i, dump_i, win_len_i, shift_i,
      output i_o, q_o, valid_o, ovf_o, win_cnt_o
   );

endinterface

// File: rtl/lia_sat.sv
// Scales an accumulator value by an arithmetic right shift and saturates it
// to a signed OUT_W result.
//   acc   in  ACC_W  signed accumulator value
//   shift in  6      right shift amount (rounds toward -inf)
//   res   out OUT_W  shifted and clipped result
//   clip  out 1      high when the shifted value was outside the OUT_W range
module lia_sat #(
   parameter int ACC_W = lia_pkg::ACC_W,
   parameter int OUT_W = lia_pkg::OUT_W
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic [5:0]              shift,
   output logic signed [OUT_W-1:0] res,
   output logic                    clip
);

   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   logic signed [ACC_W-1:0] shifted;

   assign shifted = acc >>> shift;

   always_comb begin
      res  = shifted[OUT_W-1:0];
      clip = 1'b0;
      if (shifted > ACC_W'(OUT_MAX)) begin
         res  = OUT_MAX;
         clip = 1'b1;
      end else if (shifted < ACC_W'(OUT_MIN)) begin
         res  = OUT_MIN;
         clip = 1'b1;
      end
   end

endmodule

// File: rtl/lock_in_iq_demod.sv
// Dual-phase (I/Q) lock-in demodulator. Multiplies the ADC stream by the
// in-phase and quadrature references, integrates both products over a window
// and emits a scaled, saturated I/Q pair with a valid pulse at window end.
// Pipeline: S1 registers samples and the end-of-window flag, S2 registers the
// full-precision products, S3 accumulates and dumps on the flag.
//   dac_clk_i  in  sample clock, one sample per cycle
//   dac_rst_i  in  asynchronous active-high reset
//   bus        slave side of lock_in_iq_demod_if (samples, controls, results)
module lock_in_iq_demod #(
   parameter int DW    = lia_pkg::DW,
   parameter int OUT_W = lia_pkg::OUT_W,
   parameter int CNT_W = lia_pkg::CNT_W,
   parameter int ACC_W = lia_pkg::ACC_W
) (
   input  logic              dac_clk_i,
   input  logic              dac_rst_i,
   lock_in_iq_demod_if.slave bus
);

   import lia_pkg::*;

   mode_t                mode_in;
   mode_t                mode_reg;
   logic                 mode_change;
   logic [CNT_W-1:0]     cnt_reg;
   logic [CNT_W-1:0]     cnt_next;
   logic                 last_next;
   logic                 last_s1_reg;
   logic                 last_s2_reg;
   logic                 flush;
   logic signed [DW-1:0] adc_reg;
   logic signed [DW-1:0] ref_in [2];
   logic [1:0]           clip;
   logic                 valid_reg;
   logic                 ovf_reg;
   logic [15:0]          win_cnt_reg;

   assign mode_in   = mode_t'(bus.mode_i);
   assign ref_in[0] = bus.ref_i_i;
   assign ref_in[1] = bus.ref_q_i;

   // Any mode change aborts the window in progress: counter, accumulators and
   // in-flight end-of-window flags are all cleared on that edge.
   assign mode_change = (mode_reg != mode_in);

   // A window closes at S3 only when no abort happens on the same edge.
   assign flush = last_s2_reg & ~mode_change;

   // End-of-window flag for the sample entering S1. Using >= lets a shrinking
   // win_len_i terminate the current window on the next sample.
   always_comb begin
      last_next = 1'b0;
      cnt_next  = '0;
      if (!mode_change) begin
         if (mode_in == MODE_INT) begin
            last_next = (cnt_reg >= bus.win_len_i);
            cnt_next  = last_next ? '0 : cnt_reg + CNT_W'(1);
         end else begin
            last_next = bus.dump_i;
         end
      end
   end

   always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
      if (dac_rst_i) begin
         adc_reg     <= '0;
         mode_reg    <= MODE_EXT;
         cnt_reg     <= '0;
         last_s1_reg <= 1'b0;
         last_s2_reg <= 1'b0;
         valid_reg   <= 1'b0;
         ovf_reg     <= 1'b0;
         win_cnt_reg <= '0;
      end else begin
         adc_reg     <= bus.adc_i;
         mode_reg    <= mode_in;
         cnt_reg     <= cnt_next;
         last_s1_reg <= last_next;
         last_s2_reg <= mode_change ? 1'b0 : last_s1_reg;
         valid_reg   <= flush;
         ovf_reg     <= flush & (|clip);
         if (flush) begin
            win_cnt_reg <= win_cnt_reg + 16'd1;
         end
      end
   end

   // Channel 0 = in-phase, channel 1 = quadrature.
   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic signed [DW-1:0]    ref_reg;
      logic signed [2*DW-1:0]  prod_reg;
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] acc_next;
      logic signed [OUT_W-1:0] sat_res;
      logic signed [OUT_W-1:0] out_reg;

      // The flagged sample is part of the closing window, so the dump value
      // is taken from acc_next rather than acc_reg.
      assign acc_next = acc_reg + ACC_W'(prod_reg);

      always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
         if (dac_rst_i) begin
            ref_reg  <= '0;
            prod_reg <= '0;
            acc_reg  <= '0;
            out_reg  <= '0;
         end else begin
            ref_reg  <= ref_in[gi];
            prod_reg <= (2*DW)'(adc_reg) * (2*DW)'(ref_reg);
            if (mode_change || last_s2_reg) begin
               acc_reg <= '0;
            end else begin
               acc_reg <= acc_next;
            end
            if (flush) begin
               out_reg <= sat_res;
            end
         end
      end

      lia_sat #(
         .ACC_W (ACC_W),
         .OUT_W (OUT_W)
      ) u_sat (
         .acc   (acc_next),
         .shift (bus.shift_i),
         .res   (sat_res),
         .clip  (clip[gi])
      );
   end

   assign bus.i_o       = g_ch[0].out_reg;
   assign bus.q_o       = g_ch[1].out_reg;
   assign bus.valid_o   = valid_reg;
   assign bus.ovf_o     = ovf_reg;
   assign bus.win_cnt_o = win_cnt_reg;

endmodule

// File: tb/tb_lock_in_iq_demod.sv
// Testbench for lock_in_iq_demod: directed stimulus, a sample-level
// behavioural model checked every cycle, and hand-computed literal checks.
module tb_lock_in_iq_demod;

   localparam int     OUT_W = 14;
   localparam longint OMAX  = longint'(2**(OUT_W-1)) - 1;
   localparam longint OMIN  = -longint'(2**(OUT_W-1));

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit quiet = 1'b0;

   lock_in_iq_demod_if bus ();

   lock_in_iq_demod dut (
      .dac_clk_i (clk),
      .dac_rst_i (rst),
      .bus       (bus)
   );

   // ---------------- behavioural model ----------------
   // Each sample becomes a record {I product, Q product, last-of-window}.
   // A record is summed into the running window two edges after it was
   // sampled; a flagged record closes the window and produces the result.
   typedef struct {
      longint pi;
      longint pq;
      bit     flag;
   } rec_t;

   rec_t        mq[$];
   bit          m_mode  = 1'b0;
   int          m_cnt   = 0;
   longint      s_i     = 0;
   longint      s_q     = 0;
   bit          e_valid = 1'b0;
   bit          e_ovf   = 1'b0;
   logic [15:0] e_cnt   = '0;
   longint      e_i     = 0;
   longint      e_q     = 0;

   function automatic longint clip_val(input longint v, output bit c);
      c = 1'b0;
      if (v > OMAX) begin
         c = 1'b1;
         return OMAX;
      end
      if (v < OMIN) begin
         c = 1'b1;
         return OMIN;
      end
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      rec_t r;
      rec_t r0;
      bit   chg;
      bit   ci;
      bit   cq;
      if (rst) begin
         mq.delete();
         m_mode  = 1'b0;
         m_cnt   = 0;
         s_i     = 0;
         s_q     = 0;
         e_valid = 1'b0;
         e_ovf   = 1'b0;
         e_cnt   = '0;
         e_i     = 0;
         e_q     = 0;
      end else begin
         chg    = (bus.mode_i != m_mode);
         r.pi   = longint'(bus.adc_i) * longint'(bus.ref_i_i);
         r.pq   = longint'(bus.adc_i) * longint'(bus.ref_q_i);
         r.flag = 1'b0;
         if (chg) begin
            // aborted window: the previous sample's flag is cancelled too
            m_cnt = 0;
            if (mq.size() > 0) mq[mq.size()-1].flag = 1'b0;
         end else if (bus.mode_i) begin
            r.flag = (m_cnt >= int'(bus.win_len_i));
            m_cnt  = r.flag ? 0 : m_cnt + 1;
         end else begin
            r.flag = bus.dump_i;
            m_cnt  = 0;
         end
         m_mode = bus.mode_i;
         mq.push_back(r);
         e_valid = 1'b0;
         e_ovf   = 1'b0;
         if (mq.size() == 3) begin
            r0 = mq.pop_front();
            if (chg) begin
               s_i = 0;
               s_q = 0;
            end else begin
               s_i += r0.pi;
               s_q += r0.pq;
               if (r0.flag) begin
                  e_i     = clip_val(s_i >>> bus.shift_i, ci);
                  e_q     = clip_val(s_q >>> bus.shift_i, cq);
                  e_ovf   = ci | cq;
                  e_valid = 1'b1;
                  e_cnt   = e_cnt + 16'd1;
                  s_i     = 0;
                  s_q     = 0;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (bus.valid_o !== e_valid || bus.ovf_o !== e_ovf || bus.win_cnt_o !== e_cnt ||
             longint'(bus.i_o) != e_i || longint'(bus.q_o) != e_q) begin
            bad++;
            $display("FAIL cycle @%0t: got v=%0b ovf=%0b cnt=%0d i=%0d q=%0d want v=%0b ovf=%0b cnt=%0d i=%0d q=%0d",
                     $time, bus.valid_o, bus.ovf_o, bus.win_cnt_o, bus.i_o, bus.q_o,
                     e_valid, e_ovf, e_cnt, e_i, e_q);
         end else if (e_valid && !quiet) begin
            $display("txn @%0t: win_cnt=%0d i=%0d q=%0d ovf=%0b",
                     $time, bus.win_cnt_o, bus.i_o, bus.q_o, bus.ovf_o);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, input int limit, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < limit) begin
         tick();
         cycles++;
         if (bus.valid_o) seen = 1'b1;
      end
      check(name, longint'(seen), 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_i"},     longint'(bus.i_o), 0);
      check({tag, "_q"},     longint'(bus.q_o), 0);
      check({tag, "_valid"}, longint'(bus.valid_o), 0);
      check({tag, "_ovf"},   longint'(bus.ovf_o), 0);
      check({tag, "_cnt"},   longint'(bus.win_cnt_o), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int          cyc;
      bit          wrapped;
      logic [15:0] prev;

      bus.adc_i     = '0;
      bus.ref_i_i   = '0;
      bus.ref_q_i   = '0;
      bus.mode_i    = 1'b0;
      bus.dump_i    = 1'b0;
      bus.win_len_i = '0;
      bus.shift_i   = '0;

      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst = 1'b0;

      // External dump: flags at sample A and A+3.
      bus.ref_i_i = 14'sd1;
      bus.ref_q_i = -14'sd1;
      tick();
      tick();
      bus.adc_i = 14'sd3; bus.dump_i = 1'b1; tick();
      check("dump_v_a0", longint'(bus.valid_o), 0);
      bus.adc_i = 14'sd5; bus.dump_i = 1'b0; tick();
      check("dump_v_a1", longint'(bus.valid_o), 0);
      bus.adc_i = 14'sd6; tick();
      check("dump_v_a2", longint'(bus.valid_o), 1);
      check("dump_i_w1", longint'(bus.i_o), 3);
      bus.adc_i = 14'sd7; bus.dump_i = 1'b1; tick();
      check("dump_v_a3", longint'(bus.valid_o), 0);
      bus.adc_i = 14'sd0; bus.dump_i = 1'b0; tick();
      check("dump_v_a4", longint'(bus.valid_o), 0);
      tick();
      check("dump_v_a5", longint'(bus.valid_o), 1);
      check("dump_i_w2", longint'(bus.i_o), 18);
      check("dump_q_w2", longint'(bus.q_o), -18);
      check("dump_cnt",  longint'(bus.win_cnt_o), 2);

      // Saturation, internal 4-sample windows.
      bus.adc_i     = 14'sd8191;
      bus.ref_i_i   = 14'sd8191;
      bus.ref_q_i   = -14'sd8192;
      bus.shift_i   = 6'd0;
      bus.win_len_i = 24'd3;
      bus.mode_i    = 1'b1;
      wait_valid("sat_valid", 20, cyc);
      check("sat_i",   longint'(bus.i_o), 8191);
      check("sat_q",   longint'(bus.q_o), -8192);
      check("sat_ovf", longint'(bus.ovf_o), 1);

      // Internal DC window of 125 samples.
      bus.adc_i     = 14'sd100;
      bus.ref_i_i   = 14'sd200;
      bus.ref_q_i   = -14'sd50;
      bus.shift_i   = 6'd10;
      bus.win_len_i = 24'd124;
      repeat (5) tick();
      wait_valid("dc_skip", 300, cyc);
      wait_valid("dc_valid1", 300, cyc);
      check("dc_i",   longint'(bus.i_o), 2441);
      check("dc_q",   longint'(bus.q_o), -611);
      check("dc_ovf", longint'(bus.ovf_o), 0);
      wait_valid("dc_valid2", 300, cyc);
      check("dc_period", longint'(cyc), 125);
      check("dc_i2",     longint'(bus.i_o), 2441);

      // 1-sample windows until the window counter wraps.
      bus.win_len_i = 24'd0;
      bus.adc_i     = 14'sd1;
      bus.ref_i_i   = 14'sd1;
      bus.ref_q_i   = 14'sd1;
      bus.shift_i   = 6'd0;
      quiet   = 1'b1;
      wrapped = 1'b0;
      prev    = bus.win_cnt_o;
      for (int n = 0; n < 70000 && !wrapped; n++) begin
         tick();
         if (bus.valid_o && bus.win_cnt_o == 16'd0 && prev == 16'hffff) wrapped = 1'b1;
         prev = bus.win_cnt_o;
      end
      quiet = 1'b0;
      check("cnt_wrap", longint'(wrapped), 1);

      // Mode switch while flags are in flight: no valid for the aborted window.
      bus.adc_i = 14'sd0;
      repeat (3) tick();
      check("pre_abort_valid", longint'(bus.valid_o), 1);
      bus.mode_i = 1'b0;
      bus.dump_i = 1'b0;
      tick();
      check("abort_v0", longint'(bus.valid_o), 0);
      tick();
      check("abort_v1", longint'(bus.valid_o), 0);
      repeat (5) tick();
      bus.adc_i   = 14'sd2;
      bus.ref_i_i = 14'sd3;
      bus.ref_q_i = -14'sd4;
      repeat (3) tick();
      bus.dump_i = 1'b1; tick();
      bus.adc_i  = 14'sd0; bus.dump_i = 1'b0; tick();
      tick();
      check("post_switch_v", longint'(bus.valid_o), 1);
      check("post_switch_i", longint'(bus.i_o), 24);
      check("post_switch_q", longint'(bus.q_o), -32);

      // Reset in the middle of an internal window.
      bus.mode_i    = 1'b1;
      bus.win_len_i = 24'd124;
      bus.adc_i     = 14'sd100;
      bus.ref_i_i   = 14'sd200;
      bus.ref_q_i   = -14'sd50;
      bus.shift_i   = 6'd10;
      repeat (60) tick();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_zero_outputs("midrst");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      wait_valid("rst_first_valid", 300, cyc);
      check("rst_full_window", longint'(cyc >= 125), 1);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lock_in_iq_demod.md
# lock_in_iq_demod

Parametrised dual-phase (I/Q) lock-in demodulator for the Red Pitaya FPGA signal path. It multiplies one ADC stream by in-phase and quadrature references and integrates each product over a window. The window ends on an external dump strobe or on an internal sample counter. At the end of each window it emits a scaled, saturated I/Q pair with a valid pulse. It sits between the ADC input and the DAC output mux, driven by the modulation generator's references.

## Interface
Parameters:
- DW, 14, signed width of ADC and reference samples
- OUT_W, 14, signed width of I/Q outputs
- CNT_W, 24, width of window-length counter
- ACC_W, 52, accumulator width; must be ≥ 2·DW + CNT_W, so no overflow is possible at maximum window length

Ports:
- dac_clk_i  in  1  125 MHz sample clock; one sample per cycle
- dac_rst_i  in  1  reset; asynchronous assert, active-high
- adc_i  in  DW  signed ADC sample
- ref_i_i  in  DW  signed in-phase reference
- ref_q_i  in  DW  signed quadrature reference
- mode_i  in  1  0 = external dump (dump_i), 1 = internal counter
- dump_i  in  1  marks the current sample as the last in its window (mode 0 only)
- win_len_i  in  CNT_W  internal window = win_len_i + 1 samples (mode 1)
- shift_i  in  6  arithmetic right shift applied before saturation (0..ACC_W-1)
- i_o  out  OUT_W  signed in-phase result
- q_o  out  OUT_W  signed quadrature result
- valid_o  out  1  one-cycle pulse when i_o/q_o are updated
- ovf_o  out  1  high with valid_o if either result was clipped
- win_cnt_o  out  16  count of completed windows; wraps at 2^16

## Operation
- S1: register adc_i, ref_i_i and ref_q_i. Also register the last flag and mode_i.
- Last flag:
  - mode 0: last = dump_i.
  - mode 1: last = (counter ≥ win_len_i). The counter increments once per sample and loads 0 on last.
  - The ≥ comparison makes a shrinking win_len_i end the window immediately.
- S2: register the full-precision 2·DW signed products p_i = adc·ref_i and p_q = adc·ref_q. The flag travels with them.
- S3: form acc_next = acc + sign-extended p.
  - If the flag is set: compute r = acc_next >>> shift_i, clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and register it to i_o/q_o. Also set valid_o, set ovf_o = (clip_i | clip_q), increment win_cnt_o, and load acc with 0.
  - If the flag is clear: acc ← acc_next, valid_o = 0, ovf_o = 0.
- The flagged sample belongs to the ending window. The next sample starts the new window.
- A mode_i change, detected as registered mode ≠ mode_i:
  - clears the counter, both accumulators, and all in-flight flags;
  - produces no valid_o for the aborted window.
- In mode 1, dump_i is ignored. In mode 0, the counter is held at 0.
- i_o/q_o hold their value between valid pulses.

## Timing
- On reset, every register is 0: i_o = 0, q_o = 0, valid_o = 0, ovf_o = 0, win_cnt_o = 0, accumulators 0, counter 0, pipeline flags 0.
- Reset mid-window discards the partial sums. Deassertion is synchronised externally.
- Latency: a sample or dump_i sampled at edge k contributes to an output registered at edge k+2. valid_o is high for exactly the cycle after edge k+2.
- dump_i high on consecutive cycles gives 1-sample windows, with valid_o high on consecutive cycles.
- win_len_i = 0 also gives 1-sample windows with valid_o every cycle.
- Throughput: one sample per cycle, no stalls, no backpressure. Downstream must accept every valid_o.
- shift_i and win_len_i are sampled live. Changes take effect on the next sample at S1 (win_len_i) or S3 (shift_i).

## Structure
- Shared package lia_pkg holds:
  - default widths DW, OUT_W, CNT_W, ACC_W;
  - the mode encodings MODE_EXT = 0 and MODE_INT = 1.
- Sub-module lia_sat (ACC_W in, OUT_W out) performs the shift, clip and clip flag. It is instantiated twice, once for I and once for Q.
- All other logic (pipeline, counter, accumulators, window counter) lives in lock_in_iq_demod.

## Test plan
- Reset: assert dac_rst_i mid-window -> all outputs 0 immediately. After release, the first valid_o appears only after a full new window.
- Internal DC window:
  - Stimulus: mode 1, win_len_i = 124, adc = 100, ref_i = 200, ref_q = -50, shift_i = 10.
  - Expected: valid_o every 125 cycles, i_o = 2,500,000>>>10 = 2441, q_o = -625,000>>>10 = -611 (arithmetic shift rounds toward -inf), ovf_o = 0.
- External dump latency: mode 0, dump_i pulsed at edges 10 and 13 -> valid_o in the cycles after edges 12 and 15. The second window sums exactly 3 samples.
- Saturation:
  - Stimulus: adc = 8191, ref_i = 8191, ref_q = -8192, win_len_i = 3, shift_i = 0.
  - Expected: i_o = 8191, q_o = -8192, ovf_o = 1 coincident with valid_o.
- Mode switch and window count: switch mode_i mid-window -> no valid_o for the aborted window. Later windows are correct, and win_cnt_o wraps 65535 -> 0.
